filter_fir_sched: RTL and testbench
===================================

# filter_fir_sched

Round-robin scheduler that time-shares one fixed-point filter datapath among `N_CH` sample sources. It accepts samples over per-channel valid/ready ports, issues one sample per transaction to the filter through a strobe/clear interface, and captures the filter result after a fixed latency. It returns the result, tagged with its source channel, on a single valid/ready output port. It also sequences filter clearing after reset and on request, and sits between the sample sources and the `filter_fir` datapath.

## Interface
- `NB_INPUT`, 8: sample width, signed Q2.6.
- `NB_OUTPUT`, 12: filter result width, signed.
- `N_CH`, 4: number of requesting channels, 2..16.
- `NB_CH`, `$clog2(N_CH)`: channel tag width.
- `LATENCY`, 1: cycles from the filter strobe to a valid `f_y`. Must be ≥1.
- `FLUSH_LEN`, 3: number of cycles `f_clr_n` is held low per flush. Must be ≥1.

- `clk` in 1: single clock, posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `s_valid` in N_CH: per-channel sample valid.
- `s_data` in N_CH*NB_INPUT: channel i at bits [i*NB_INPUT +: NB_INPUT].
- `s_ready` out N_CH: one-hot grant/accept.
- `flush_req` in 1: single-cycle pulse that requests a filter clear.
- `flush_busy` out 1: high while clearing.
- `f_x` out NB_INPUT: sample to the filter, registered.
- `f_en` out 1: filter advance strobe, registered, one cycle per sample.
- `f_clr_n` out 1: filter clear, active-low, registered.
- `f_y` in NB_OUTPUT: filter result.
- `m_valid` out 1, `m_ready` in 1: result handshake.
- `m_data` out NB_OUTPUT: captured result.
- `m_ch` out NB_CH: source channel of `m_data`.
- `done_cnt` out 16: completed output transfers; wraps at 0xFFFF→0.

## Operation
- FSM states: FLUSH, IDLE, ISSUE, WAIT, HOLD. The reset state is FLUSH.
- **FLUSH:**
  - Drive `f_clr_n`=0 and `flush_busy`=1 for FLUSH_LEN cycles; then go to IDLE.
  - `s_ready`=0 throughout.
- **IDLE:**
  - A pending flush (see below) takes priority: go to FLUSH.
  - Otherwise, when any `s_valid` is high, grant the first valid channel searching upward from `last_grant`+1 (mod N_CH).
  - `s_ready[g]`=1 is combinational from `s_valid` and `last_grant`; only one bit is ever high.
  - On the accept edge, register `f_x`←`s_data[g]`, set `tag`←g and `last_grant`←g, and go to ISSUE.
- **ISSUE:** exactly one cycle with `f_en`=1; go to WAIT.
- **WAIT:**
  - Count LATENCY cycles.
  - On the edge ending the last WAIT cycle, capture `m_data`←`f_y` and `m_ch`←`tag`, set `m_valid`=1, and go to HOLD.
- **HOLD:**
  - Hold `m_valid`, `m_data` and `m_ch` stable until `m_valid`&`m_ready`.
  - On that edge, clear `m_valid`, increment `done_cnt`, and go to IDLE.
- **Flush pending flag:**
  - Set by `flush_req` in any state.
  - Cleared on entry to FLUSH.
  - A `flush_req` arriving while already in FLUSH re-arms the flag, so one more full flush follows.
- A flush never discards a sample already accepted. That transaction completes through HOLD first.
- `last_grant` is unchanged by flushes and resets to N_CH-1, so channel 0 has first priority.
- Arithmetic: no arithmetic on the sample data; `f_x` and `m_data` pass bit-exact. `done_cnt` wraps modulo 2^16.

## Timing
- **Reset values while `rst_n`=0:**
  - State FLUSH, with the flush count at 0.
  - `f_clr_n`=0 and `flush_busy`=1.
  - `f_en`=0, `f_x`=0, `s_ready`=0.
  - `m_valid`=0, `m_data`=0, `m_ch`=0, `done_cnt`=0.
  - `last_grant`=N_CH-1; flush pending flag=0.
- After release, `f_clr_n` stays low for FLUSH_LEN rising edges, then goes high with `flush_busy`=0.
- **Per-sample timeline** (accept at cycle 0):
  - `f_en`=1 in cycle 1.
  - WAIT in cycles 2..1+LATENCY.
  - `m_valid`=1 from cycle 2+LATENCY.
  - With `m_ready` tied high, the next accept can occur at cycle 3+LATENCY, giving a minimum period of 3+LATENCY cycles.
- `f_en` pulses are never back-to-back, and never coincide with `f_clr_n`=0.
- **Asynchronous reset mid-transaction:**
  - The transaction is abandoned and all outputs take their reset values immediately.
  - The accepted sample is lost and no `m_valid` is produced for it.
- `m_ready` high before `m_valid` has no effect. Dropping `s_valid` while IDLE without a grant has no effect.

## Test plan
- **Reset flush:** release `rst_n` with FLUSH_LEN=3 → `f_clr_n`=0 for exactly 3 cycles, then 1; no `s_ready` during this time; all outputs at reset values beforehand.
- **Single channel:** ch2 sends 0x40, the filter model returns 0x123 → `f_x`=0x40 with `f_en` in cycle 1; `m_valid` at cycle 3 with `m_data`=0x123 and `m_ch`=2; `done_cnt`=1.
- **Round-robin:** all four `s_valid` held high, `m_ready`=1 → grant order 0,1,2,3,0; accepts spaced exactly 4 cycles apart (LATENCY=1).
- **Backpressure:** `m_ready`=0 for 10 cycles → `m_data`/`m_ch` stable; no `s_ready` and no `f_en`; on `m_ready`=1, exactly one transfer and `done_cnt`+1.
- **Flush during transaction:** `flush_req` pulsed in WAIT → the result is still delivered, then FLUSH runs for 3 cycles before the next grant, with pending `s_valid` ignored during FLUSH.
- **Reset mid-op:** assert `rst_n`=0 in WAIT → `m_valid` never rises for that sample; after release, a fresh flush runs and ch0 gets first grant.

Source files
------------

// File: rtl/filter_fir_sched.sv
// Round-robin scheduler sharing one filter datapath among N_CH sample sources.
// Issues one strobe per sample, captures the result after LATENCY cycles, and sequences filter clears.
module filter_fir_sched #(
    parameter int NB_INPUT  = 8,
    parameter int NB_OUTPUT = 12,
    parameter int N_CH      = 4,
    parameter int NB_CH     = $clog2(N_CH),
    parameter int LATENCY   = 1,
    parameter int FLUSH_LEN = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_CH-1:0]          s_valid,
    input  logic [N_CH*NB_INPUT-1:0] s_data,
    output logic [N_CH-1:0]          s_ready,
    input  logic                     flush_req,
    output logic                     flush_busy,
    output logic [NB_INPUT-1:0]      f_x,
    output logic                     f_en,
    output logic                     f_clr_n,
    input  logic [NB_OUTPUT-1:0]     f_y,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [NB_OUTPUT-1:0]     m_data,
    output logic [NB_CH-1:0]         m_ch,
    output logic [15:0]              done_cnt
);

    localparam int unsigned NCH_U   = N_CH;
    localparam int          CNT_MAX = (FLUSH_LEN > LATENCY) ? FLUSH_LEN : LATENCY;
    localparam int          CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        ST_FLUSH,
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_HOLD
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 pend_q, pend_d;
    logic [NB_CH-1:0]     last_grant_q, last_grant_d;
    logic [NB_CH-1:0]     tag_q, tag_d;
    logic [NB_INPUT-1:0]  f_x_q, f_x_d;
    logic                 f_en_q, f_en_d;
    logic                 f_clr_n_q, f_clr_n_d;
    logic                 m_valid_q, m_valid_d;
    logic [NB_OUTPUT-1:0] m_data_q, m_data_d;
    logic [NB_CH-1:0]     m_ch_q, m_ch_d;
    logic [15:0]          done_q, done_d;

    logic                 grant_valid;
    logic [NB_CH-1:0]     grant_idx;
    logic [NB_CH-1:0]     cand;

    // First valid channel searching upward from last_grant+1, wrapping at N_CH.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned i = 0; i < NCH_U; i++) begin
            cand = NB_CH'((32'(last_grant_q) + i + 32'd1) % NCH_U);
            if (!grant_valid && s_valid[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        s_ready = '0;
        if (state_q == ST_IDLE && !pend_q && grant_valid) begin
            s_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pend_d       = pend_q;
        last_grant_d = last_grant_q;
        tag_d        = tag_q;
        f_x_d        = f_x_q;
        m_valid_d    = m_valid_q;
        m_data_d     = m_data_q;
        m_ch_d       = m_ch_q;
        done_d       = done_q;

        unique case (state_q)
            ST_FLUSH: begin
                if (cnt_q == CNT_W'(FLUSH_LEN - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_IDLE: begin
                if (pend_q) begin
                    state_d = ST_FLUSH;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                end else if (grant_valid) begin
                    f_x_d        = s_data[grant_idx*NB_INPUT +: NB_INPUT];
                    tag_d        = grant_idx;
                    last_grant_d = grant_idx;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
            ST_WAIT: begin
                if (cnt_q == CNT_W'(LATENCY - 1)) begin
                    m_data_d  = f_y;
                    m_ch_d    = tag_q;
                    m_valid_d = 1'b1;
                    state_d   = ST_HOLD;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    done_d    = done_q + 16'd1;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_FLUSH;
                cnt_d   = '0;
            end
        endcase

        // A request on the flush-entry edge wins, so it buys one more full flush.
        if (flush_req) begin
            pend_d = 1'b1;
        end

        f_en_d    = (state_d == ST_ISSUE);
        f_clr_n_d = (state_d != ST_FLUSH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_FLUSH;
            cnt_q        <= '0;
            pend_q       <= 1'b0;
            last_grant_q <= NB_CH'(N_CH - 1);
            tag_q        <= '0;
            f_x_q        <= '0;
            f_en_q       <= 1'b0;
            f_clr_n_q    <= 1'b0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_ch_q       <= '0;
            done_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            last_grant_q <= last_grant_d;
            tag_q        <= tag_d;
            f_x_q        <= f_x_d;
            f_en_q       <= f_en_d;
            f_clr_n_q    <= f_clr_n_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            m_ch_q       <= m_ch_d;
            done_q       <= done_d;
        end
    end

    assign flush_busy = (state_q == ST_FLUSH);
    assign f_x        = f_x_q;
    assign f_en       = f_en_q;
    assign f_clr_n    = f_clr_n_q;
    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign m_ch       = m_ch_q;
    assign done_cnt   = done_q;

endmodule

// File: tb/tb_filter_fir_sched.sv
// Bench for filter_fir_sched: integrator filter stand-in, transaction-level reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_filter_fir_sched;

    localparam int NB_INPUT  = 8;
    localparam int NB_OUTPUT = 12;
    localparam int N_CH      = 4;
    localparam int NB_CH     = 2;
    localparam int LATENCY   = 1;
    localparam int FLUSH_LEN = 3;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [N_CH-1:0]          s_valid;
    logic [N_CH*NB_INPUT-1:0] s_data;
    logic [N_CH-1:0]          s_ready;
    logic                     flush_req;
    logic                     flush_busy;
    logic [NB_INPUT-1:0]      f_x;
    logic                     f_en;
    logic                     f_clr_n;
    logic [NB_OUTPUT-1:0]     f_y;
    logic                     m_valid;
    logic                     m_ready;
    logic [NB_OUTPUT-1:0]     m_data;
    logic [NB_CH-1:0]         m_ch;
    logic [15:0]              done_cnt;

    always #5 clk = ~clk;

    filter_fir_sched #(
        .NB_INPUT (NB_INPUT),
        .NB_OUTPUT(NB_OUTPUT),
        .N_CH     (N_CH),
        .NB_CH    (NB_CH),
        .LATENCY  (LATENCY),
        .FLUSH_LEN(FLUSH_LEN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .flush_req (flush_req),
        .flush_busy(flush_busy),
        .f_x       (f_x),
        .f_en      (f_en),
        .f_clr_n   (f_clr_n),
        .f_y       (f_y),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_ch      (m_ch),
        .done_cnt  (done_cnt)
    );

    // Filter stand-in: running sum of strobed samples, cleared while f_clr_n is low.
    logic [NB_OUTPUT-1:0] acc;
    logic                 fy_force;
    always @(posedge clk) begin
        if (!f_clr_n) acc <= '0;
        else if (f_en) acc <= acc + {{(NB_OUTPUT-NB_INPUT){f_x[NB_INPUT-1]}}, f_x};
    end
    assign f_y = fy_force ? 12'h123 : acc;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [N_CH-1:0] v, input int last);
        for (int i = 1; i <= N_CH; i++) begin
            int c;
            c = (last + i) % N_CH;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic int oh_idx(input logic [N_CH-1:0] v);
        for (int i = 0; i < N_CH; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Reference model: flush cycles left, pending flag, cycles since accept (-1 = none).
    int                   mflush;
    bit                   mpend;
    int                   mphase;
    int                   mlast;
    logic [NB_OUTPUT-1:0] msum;
    logic [NB_OUTPUT-1:0] mexp_data;
    int                   mexp_ch;
    logic [NB_INPUT-1:0]  mexp_x;
    logic [15:0]          mdone;

    // Compare at the negedge, then advance the model with the inputs the next posedge will see.
    initial begin : compare
        logic [N_CH-1:0]     exp_sr;
        logic [NB_INPUT-1:0] x;
        bit                  flushing;
        bit                  holding;
        int                  g;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mflush = FLUSH_LEN;
                mpend  = 1'b0;
                mphase = -1;
                mlast  = N_CH - 1;
                msum   = '0;
                mdone  = '0;
            end
            flushing = (mflush > 0);
            holding  = (mphase >= 2 + LATENCY);
            exp_sr   = '0;
            g        = -1;
            if (!flushing && mphase < 0 && !mpend) begin
                g = rr_pick(s_valid, mlast);
                if (g >= 0) exp_sr[g] = 1'b1;
            end
            chk("f_clr_n", 32'(f_clr_n), 32'(!flushing));
            chk("flush_busy", 32'(flush_busy), 32'(flushing));
            chk("s_ready", 32'(s_ready), 32'(exp_sr));
            chk("f_en", 32'(f_en), 32'(mphase == 1));
            if (mphase == 1) chk("f_x", 32'(f_x), 32'(mexp_x));
            chk("m_valid", 32'(m_valid), 32'(holding));
            if (holding) begin
                chk("m_data", 32'(m_data), 32'(mexp_data));
                chk("m_ch", 32'(m_ch), 32'(mexp_ch));
            end
            chk("done_cnt", 32'(done_cnt), 32'(mdone));

            if (rst_n) begin
                if (flushing) begin
                    mflush--;
                    msum = '0;
                    if (flush_req) mpend = 1'b1;
                end else if (mphase < 0) begin
                    if (mpend) begin
                        mflush = FLUSH_LEN;
                        mpend  = flush_req;
                    end else begin
                        if (g >= 0) begin
                            x         = s_data[g*NB_INPUT +: NB_INPUT];
                            mphase    = 1;
                            mlast     = g;
                            mexp_x    = x;
                            msum      = msum + {{(NB_OUTPUT-NB_INPUT){x[NB_INPUT-1]}}, x};
                            mexp_data = fy_force ? 12'h123 : msum;
                            mexp_ch   = g;
                        end
                        if (flush_req) mpend = 1'b1;
                    end
                end else begin
                    if (holding) begin
                        if (m_ready) begin
                            mphase = -1;
                            mdone  = mdone + 16'd1;
                        end
                    end else begin
                        mphase++;
                    end
                    if (flush_req) mpend = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n;
        int cnt;
        int gidx[5];
        int gcyc[5];
        logic [NB_OUTPUT-1:0] hold_d;
        logic [NB_CH-1:0]     hold_c;
        logic [15:0]          hold_n;

        rst_n = 1'b0; s_valid = '0; s_data = '0; flush_req = 1'b0; m_ready = 1'b1; fy_force = 1'b0;
        repeat (2) tick();

        // Reset values
        chk("rst_f_clr_n", 32'(f_clr_n), 32'd0);
        chk("rst_flush_busy", 32'(flush_busy), 32'd1);
        chk("rst_f_en", 32'(f_en), 32'd0);
        chk("rst_f_x", 32'(f_x), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_m_ch", 32'(m_ch), 32'd0);
        chk("rst_done", 32'(done_cnt), 32'd0);

        // Reset flush, then single channel 2 with filter forced to 0x123
        s_valid  = 4'b0100;
        s_data   = 32'h0040_0000;
        fy_force = 1'b1;
        rst_n    = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (f_clr_n) break;
            n++;
        end
        chk("reset_flush_len", 32'(n), 32'd3);
        chk("single_grant", 32'(s_ready), 32'b0100);
        tick();
        s_valid = '0;
        @(negedge clk);
        chk("single_f_en", 32'(f_en), 32'd1);
        chk("single_f_x", 32'(f_x), 32'h40);
        @(negedge clk);
        chk("single_m_valid_c2", 32'(m_valid), 32'd0);
        @(negedge clk);
        chk("single_m_valid_c3", 32'(m_valid), 32'd1);
        chk("single_m_data", 32'(m_data), 32'h123);
        chk("single_m_ch", 32'(m_ch), 32'd2);
        @(negedge clk);
        chk("single_done", 32'(done_cnt), 32'd1);
        tick();
        fy_force = 1'b0;
        tick();

        // Reset in WAIT, then round-robin from channel 0
        s_valid = 4'b0010;
        s_data  = 32'h0000_5500;
        n = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s_ready != '0) begin n = i; break; end
        end
        chk("midrst_grant_seen", 32'(n >= 0), 32'd1);
        tick();
        s_valid = '0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_m_valid", 32'(m_valid), 32'd0);
        chk("midrst_f_clr_n", 32'(f_clr_n), 32'd0);
        chk("midrst_done", 32'(done_cnt), 32'd0);
        tick();
        s_valid = 4'hF;
        s_data  = 32'h1122_3344;
        tick();
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 80 && cnt < 5; i++) begin
            @(negedge clk);
            if (s_ready != '0) begin
                gidx[cnt] = oh_idx(s_ready);
                gcyc[cnt] = i;
                cnt++;
            end
        end
        chk("rr_count", 32'(cnt), 32'd5);
        for (int k = 0; k < 5; k++) chk("rr_order", 32'(gidx[k]), 32'(k % 4));
        for (int k = 1; k < 5; k++) chk("rr_spacing", 32'(gcyc[k] - gcyc[k-1]), 32'd4);
        tick();
        s_valid = '0;
        repeat (8) tick();

        // Backpressure
        m_ready = 1'b0;
        s_valid = 4'b0001;
        s_data  = 32'h0000_009C;
        n = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_valid) begin n = i; break; end
        end
        chk("bp_m_valid_seen", 32'(n >= 0), 32'd1);
        hold_d = m_data;
        hold_c = m_ch;
        hold_n = done_cnt;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_m_data_stable", 32'(m_data), 32'(hold_d));
            chk("bp_m_ch_stable", 32'(m_ch), 32'(hold_c));
            chk("bp_no_s_ready", 32'(s_ready), 32'd0);
            chk("bp_no_f_en", 32'(f_en), 32'd0);
        end
        tick();
        m_ready = 1'b1;
        s_valid = '0;
        @(negedge clk);
        @(negedge clk);
        chk("bp_one_transfer", 32'(done_cnt), 32'(hold_n + 16'd1));
        repeat (5) @(negedge clk);
        chk("bp_only_one", 32'(done_cnt), 32'(hold_n + 16'd1));
        tick();

        // Flush requested during WAIT
        s_valid = 4'b0100;
        s_data  = 32'h007F_0000;
        n = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s_ready != '0) begin n = i; break; end
        end
        chk("fl_grant_seen", 32'(n >= 0), 32'd1);
        tick();
        s_valid = '0;
        tick();
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        s_valid   = 4'hF;
        cnt = 0;
        n   = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i == 0) begin
                chk("fl_result_kept", 32'(m_valid), 32'd1);
                chk("fl_result_ch", 32'(m_ch), 32'd2);
            end
            if (!f_clr_n) cnt++;
            if (s_ready != '0) begin n = i; break; end
        end
        chk("fl_clear_cycles", 32'(cnt), 32'd3);
        chk("fl_next_grant_cycle", 32'(n), 32'd5);
        chk("fl_next_grant_ch", 32'(s_ready), 32'b1000);
        tick();
        s_valid = '0;
        repeat (8) tick();

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            tick();
            s_valid   = 4'($urandom);
            s_data    = $urandom;
            m_ready   = ($urandom_range(0, 3) != 0);
            rst_n     = ($urandom_range(0, 399) != 0);
            flush_req = rst_n && ($urandom_range(0, 39) == 0);
        end
        tick();
        rst_n = 1'b1; flush_req = 1'b0; s_valid = '0; m_ready = 1'b1;
        repeat (10) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
